// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request, shared-ALU and response signals of alu_share_arb.
//   req0_*/req1_* : valid/ready handshake plus op code and operands per requester
//   alu_a/alu_b   : operands to the functional units
//   alu_sel       : ALU result mux select
//   alu_result    : ALU result mux output
//   rsp_*         : tagged response handshake
// slave is the arbiter side; master is the issue/ALU/consumer side.
interface alu_share_arb_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: grants one of two requesters access to a shared ALU, holds
// operands/select for the op latency (1 cycle, MUL_LAT cycles for op 7), then
// returns the captured mux output tagged with the requester id.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_share_arb_if.slave (requests, ALU operands/select/result,
//                response)
// Build option: define ALU_SHARE_ARB_PRIO_EN for fixed priority (requester 0
// wins ties); default build is round-robin.
module alu_share_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_arb_if.slave bus
);

  localparam int unsigned CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [2:0]  OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
`ifndef ALU_SHARE_ARB_PRIO_EN
  logic             last_grant;
`endif

  logic             grant0;
  logic             grant1;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Grant decision, only while idle; ready is the grant itself.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
`ifdef ALU_SHARE_ARB_PRIO_EN
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid & ~bus.req0_valid;
`else
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
`endif
    end
  end

  // Winner's payload.
  always_comb begin
    sel_op = bus.req0_op;
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    if (grant1) begin
      sel_op = bus.req1_op;
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Sequencer: grant -> hold ALU inputs for the op latency -> hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
`ifndef ALU_SHARE_ARB_PRIO_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            bus.alu_sel <= sel_op;
            bus.alu_a   <= sel_a;
            bus.alu_b   <= sel_b;
            bus.rsp_id  <= grant1;
`ifndef ALU_SHARE_ARB_PRIO_EN
            last_grant  <= grant1;
`endif
            cnt         <= (sel_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            bus.rsp_data  <= bus.alu_result;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer that shares one ALU datapath (functional units feeding an 8:1 result mux selected by a 3-bit code). It grants one request at a time and drives the shared operand buses and the mux select. It holds the select stable for the op's latency, one cycle or MUL_LAT cycles for op 7, then captures the mux output and returns it tagged with the requester id. It sits between the issue logic and the ALU result mux.

## Interface
- WIDTH, 32, operand/result width
- MUL_LAT, 4, execute cycles for op 3'd7 (≥1); all other ops take 1 cycle

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  3  mux select code for requester 0
- req0_a, req0_b  in  WIDTH  operands for requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same for requester 1
- alu_a, alu_b  out  WIDTH  registered operands to functional units
- alu_sel  out  3  registered select to ALU result mux
- alu_result  in  WIDTH  ALU result mux output
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH  captured result

## Operation
- States: IDLE, EXEC, RESP.
- Reset: state IDLE; alu_a, alu_b, rsp_data = 0; alu_sel = 0; rsp_valid = 0; rsp_id = 0; last-grant pointer = 1, so requester 0 wins first; cycle counter = 0.
- IDLE, grant logic:
  - One valid: that requester wins.
  - Both valid: the requester not granted last wins (round-robin).
  - The winner's reqN_ready is asserted combinationally in that cycle. The other ready stays 0.
  - On that edge: latch op into alu_sel and operands into alu_a/alu_b; update the pointer; record the id; enter EXEC.
  - Counter loads MUL_LAT-1 if op==7, else 0.
- IDLE with no valid: stay; ready outputs 0. A requester may drop valid before grant with no effect.
- EXEC: alu_sel, alu_a and alu_b are held constant.
  - If counter==0: capture alu_result into rsp_data, set rsp_valid, enter RESP.
  - Otherwise decrement the counter.
- RESP: rsp_valid, rsp_id and rsp_data are held until rsp_ready=1. On that edge rsp_valid is cleared and the state returns to IDLE.
- reqN_ready is 0 in EXEC and RESP, so there is at most one op in flight.
- alu_sel/alu_a/alu_b keep their last values after completion until the next grant.
- Reset mid-operation aborts the op immediately: no response, all outputs return to reset values.

## Timing
- Grant at edge T (valid and ready both high in the cycle before T).
- EXEC occupies cycles T..T+L-1, where L=1 for ops 0-6 and L=MUL_LAT for op 7.
- rsp_valid rises after edge T+L and is visible in the cycle following that edge.
- Minimum occupancy is 3 cycles per op with rsp_ready tied high: grant, EXEC, RESP.
- The next grant is possible in the first IDLE cycle after the response handshake.
- rsp_ready held low stalls indefinitely. Requests are not dropped; their valid simply stays unanswered.
- MUL_LAT=1 makes op 7 timing identical to the other ops.

## Configuration
- ALU_SHARE_ARB_PRIO_EN defined: fixed priority. Requester 0 always wins when both are valid, and the last-grant pointer is unused.
- Not defined: round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then req0 op=2, a=5, b=3 alone -> req0_ready=1 one cycle; alu_sel=2, alu_a=5, alu_b=3 next cycle; rsp_valid with rsp_id=0 and rsp_data equal to the driven alu_result, 2 cycles after grant.
- req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. With ALU_SHARE_ARB_PRIO_EN, all grants go to 0.
- req1 op=7 with MUL_LAT=4 -> alu_sel=7 held for 4 EXEC cycles; alu_result changed each cycle; rsp_data equals the value on the 4th cycle; no ready asserted meanwhile.
- Response stall: rsp_ready=0 for 10 cycles with req0 valid -> rsp_valid and rsp_data stable; req0_ready=0 throughout; rsp_ready=1 -> req0 granted in the next IDLE cycle.
- rst_n pulsed low during EXEC of op 7 -> rsp_valid=0 and alu_sel=0 immediately; no response after release; next both-valid grant goes to requester 0.
- req0_valid pulsed for one cycle while the block is in EXEC -> never granted; no response for it.
